mux_arbiter_4x1: RTL

MUX_ARBITER_4X1 -- requirements
Module: mux_arbiter_4x1

---
 rtl/mux_arbiter_4x1.sv | 100 ++++++++++
 1 files changed

// File: rtl/mux_arbiter_4x1.sv
// mux_arbiter_4x1: four-requester valid/ready arbiter feeding a single
// registered output word. Round-robin priority with bounded burst continuation.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   req_valid  per-requester valid (bit i = requester i)
//   req_data   packed requester words, requester i at [i*DATA_W +: DATA_W]
//   req_ready  per-requester accept, one-hot or zero (combinational)
//   out_valid  output register holds an unconsumed word
//   out_data   registered selected word
//   out_ready  downstream accept
//   out_sel    index of the requester whose word sits in out_data
module mux_arbiter_4x1 #(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned MAX_BURST = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [3:0]          req_valid,
    input  logic [4*DATA_W-1:0] req_data,
    output logic [3:0]          req_ready,
    output logic                out_valid,
    output logic [DATA_W-1:0]   out_data,
    input  logic                out_ready,
    output logic [1:0]          out_sel
);

    // Burst counter holds values 0..15, enough for any legal MAX_BURST.
    localparam int unsigned CNT_W = 4;

    logic [1:0]        last;
    logic [CNT_W-1:0]  burst_cnt;

    logic              load_en;
    logic              keep_burst;
    logic              grant_found;
    logic [1:0]        grant;
    logic [1:0]        idx;
    logic              req_hs;
    logic [CNT_W-1:0]  cnt_next;
    logic [DATA_W-1:0] sel_word;

    // Grant selection: burst continuation first, else rotating scan from last+1.
    always_comb begin
        load_en     = !out_valid || out_ready;
        keep_burst  = (burst_cnt != '0) && (burst_cnt < CNT_W'(MAX_BURST)) && req_valid[last];
        grant       = last;
        grant_found = 1'b0;
        idx         = last;
        if (keep_burst) begin
            grant       = last;
            grant_found = 1'b1;
        end else begin
            for (int unsigned j = 1; j <= 4; j++) begin
                idx = last + 2'(j);
                if (!grant_found && req_valid[idx]) begin
                    grant       = idx;
                    grant_found = 1'b1;
                end
            end
        end
        // Reset gating keeps req_ready low while rst_n is held low.
        req_hs    = rst_n && load_en && grant_found;
        req_ready = req_hs ? (4'b0001 << grant) : 4'b0000;
        // A repeat grant after a full burst (sole requester) restarts at 1.
        cnt_next  = ((grant == last) && (burst_cnt < CNT_W'(MAX_BURST)))
                    ? burst_cnt + CNT_W'(1) : CNT_W'(1);
    end

    // Word selected for the current grant.
    always_comb begin
        sel_word = '0;
        for (int i = 0; i < 4; i++) begin
            if (grant == 2'(i)) begin
                sel_word = req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // Output register plus arbitration history.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sel   <= 2'd0;
            last      <= 2'd3;
            burst_cnt <= '0;
        end else if (req_hs) begin
            out_valid <= 1'b1;
            out_data  <= sel_word;
            out_sel   <= grant;
            last      <= grant;
            burst_cnt <= cnt_next;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule
